// File: rtl/pp_pixel_preproc_pkg.sv
// Shared definitions for the pixel pre-processor: per-pixel modes,
// BT.601-style integer luma weights and the datapath latency.
`default_nettype none

package pp_pixel_preproc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GREY = 2'd1,
    MODE_BIN  = 2'd2,
    MODE_INV  = 2'd3
  } mode_t;

  // Weights sum to 256 so (weighted sum >> 8) always fits in one channel.
  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  // Cycles from the capture-FIFO read strobe to the output-buffer write.
  localparam int PIPE_LAT = 3;

endpackage

`default_nettype wire

// File: rtl/pp_pixel_preproc_luma.sv
// pp_luma: two registered stages (sample, weighted products) followed by the
// combinational luma sum and mode mux that feed the output buffer write port.
`default_nettype none

module pp_luma
  import pp_pixel_preproc_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3*CW-1:0] in_data,
  input  logic [1:0]      in_mode,
  input  logic [CW-1:0]   thresh,
  output logic            out_valid,
  output logic [3*CW-1:0] out_data,
  output logic [1:0]      busy
);

  localparam int PW = 3 * CW;
  localparam int SW = CW + 8;

  logic          v1, v2;
  logic [PW-1:0] px1, px2;
  mode_t         m1, m2;
  logic [SW-1:0] pr, pg, pb;
  logic [SW-1:0] sum;
  logic [CW-1:0] y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      px1 <= '0;
      px2 <= '0;
      m1  <= MODE_PASS;
      m2  <= MODE_PASS;
      pr  <= '0;
      pg  <= '0;
      pb  <= '0;
    end else begin
      v1  <= in_valid;
      px1 <= in_data;
      m1  <= mode_t'(in_mode);
      v2  <= v1;
      px2 <= px1;
      m2  <= m1;
      pr  <= SW'(LUMA_R) * SW'(px1[PW-1 -: CW]);
      pg  <= SW'(LUMA_G) * SW'(px1[2*CW-1 -: CW]);
      pb  <= SW'(LUMA_B) * SW'(px1[CW-1:0]);
    end
  end

  assign sum = pr + pg + pb;
  assign y   = CW'(sum >> 8);

  // The threshold is compared live here, not latched per frame.
  always_comb begin
    out_data = px2;
    case (m2)
      MODE_PASS: out_data = px2;
      MODE_GREY: out_data = {y, y, y};
      MODE_BIN:  out_data = (y >= thresh) ? {PW{1'b1}} : {PW{1'b0}};
      MODE_INV:  out_data = ~px2;
      default:   out_data = px2;
    endcase
  end

  assign out_valid = v2;
  assign busy      = {1'b0, v1} + {1'b0, v2};

endmodule

`default_nettype wire

// File: rtl/pp_pixel_preproc.sv
// pp_pixel_preproc: pulls pixels from a capture FIFO, applies the per-pixel
// mode transform and queues results in a DEPTH-entry output buffer.
`default_nettype none

module pp_pixel_preproc
  import pp_pixel_preproc_pkg::*;
#(
  parameter int CW         = 4,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_mode,
  input  logic [CW-1:0]         i_thresh,
  output logic                  o_rd,
  input  logic [3*CW-1:0]       i_data,
  input  logic                  i_empty,
  input  logic                  i_rd,
  output logic [3*CW-1:0]       o_data,
  output logic                  o_valid,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overflow
);

  localparam int PW    = 3 * CW;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam int IW    = $clog2(PIPE_LAT + 1);

  // Two-flop deassert; a parallel enable chain keeps the reset net out of
  // the read-strobe logic while matching its timing exactly.
  logic rst_meta, rst_sync;
  logic run_meta, run;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
      run_meta <= 1'b0;
      run      <= 1'b0;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
      run_meta <= 1'b1;
      run      <= run_meta;
    end
  end

  logic          rd_d;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic [1:0]    luma_busy;
  logic [IW-1:0] inflight;
  logic [LW:0]   need;
  logic [LW-1:0] level;

  assign inflight = luma_busy + IW'(rd_d);
  assign need     = {1'b0, level} + (LW+1)'(inflight) + (LW+1)'(1);
  assign o_rd     = !i_rst && run && !i_empty && (need <= (LW+1)'(DEPTH));

  always_ff @(posedge i_clk or posedge rst_sync) begin
    if (rst_sync) rd_d <= 1'b0;
    else          rd_d <= o_rd;
  end

  pp_luma #(.CW(CW)) u_luma (
    .clk       (i_clk),
    .rst       (rst_sync),
    .in_valid  (rd_d),
    .in_data   (i_data),
    .in_mode   (i_mode),
    .thresh    (i_thresh),
    .out_valid (wr_en),
    .out_data  (wr_data),
    .busy      (luma_busy)
  );

  logic [PW-1:0]         mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp, rp;
  logic                  pop, full, push;

  assign pop  = i_rd && (level != '0);
  assign full = (level == LW'(DEPTH));
  assign push = wr_en && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (push) mem[wp] <= wr_data;
  end

  always_ff @(posedge i_clk or posedge rst_sync) begin
    if (rst_sync) begin
      wp         <= '0;
      rp         <= '0;
      level      <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && full) o_overflow <= 1'b1;
      o_valid <= pop;
      if (pop) o_data <= mem[rp];
    end
  end

  assign o_level = level;
  assign o_empty = (level == '0);

endmodule

`default_nettype wire

// File: tb/tb_pp_pixel_preproc.sv
// Directed bench for pp_pixel_preproc: a capture-FIFO source model, a
// behavioural expected-output queue and literal checks on key vectors.
`default_nettype none
`timescale 1ns/1ps

module tb_pp_pixel_preproc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_mode;
  logic [3:0]  i_thresh;
  logic        o_rd;
  logic [11:0] i_data;
  logic        i_empty;
  logic        i_rd;
  logic [11:0] o_data;
  logic        o_valid;
  logic        o_empty;
  logic [9:0]  o_level;
  logic        o_overflow;

  int tests = 0;
  int fails = 0;
  int n_out = 0;
  int pushed = 0;
  int popped = 0;

  logic [11:0] src_pix  [2048];
  logic [1:0]  src_mode [2048];
  logic [11:0] exp_q [$];
  logic [11:0] got [$];

  always #5 clk = ~clk;

  pp_pixel_preproc #(.CW(4), .ADDR_WIDTH(9)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mode     (i_mode),
    .i_thresh   (i_thresh),
    .o_rd       (o_rd),
    .i_data     (i_data),
    .i_empty    (i_empty),
    .i_rd       (i_rd),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_empty    (o_empty),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  function automatic logic [11:0] model(input logic [11:0] p, input logic [1:0] m,
                                        input logic [3:0] th);
    int r, g, b, y;
    logic [3:0] y4;
    r  = int'(p[11:8]);
    g  = int'(p[7:4]);
    b  = int'(p[3:0]);
    y  = (77 * r + 150 * g + 29 * b) / 256;
    y4 = 4'(y);
    case (m)
      2'd0:    return p;
      2'd1:    return {y4, y4, y4};
      2'd2:    return (y4 >= th) ? 12'hFFF : 12'h000;
      default: return ~p;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [11:0] p, input logic [1:0] m);
    src_pix[pushed]  = p;
    src_mode[pushed] = m;
    pushed++;
  endtask

  // Capture-FIFO model: data and mode appear the cycle after o_rd.
  assign i_empty = (pushed == popped);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      popped <= pushed;
      exp_q.delete();
    end else if (o_rd && popped != pushed) begin
      i_data <= src_pix[popped];
      i_mode <= src_mode[popped];
      exp_q.push_back(model(src_pix[popped], src_mode[popped], i_thresh));
      popped <= popped + 1;
    end
  end

  always @(negedge clk) begin
    if (o_valid) begin
      n_out++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stream: unexpected output %0h, none expected", o_data);
      end else begin
        check("stream", o_data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_level(input int k, input int bound);
    int cyc = 0;
    while (o_level != 10'(k) && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= bound) begin
      tests++;
      fails++;
      $display("FAIL wait_level: got %0d expected %0d", o_level, k);
    end
  endtask

  task automatic drain(input int k);
    got.delete();
    wait_level(k, 200);
    for (int i = 0; i <= k; i++) begin
      i_rd = (i < k);
      @(negedge clk);
      if (o_valid) got.push_back(o_data);
    end
    i_rd = 1'b0;
    check("drain_count", got.size(), k);
    while (got.size() < k) got.push_back(12'hxxx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int out0, cyc;
    rst      = 1'b1;
    i_rd     = 1'b0;
    i_thresh = 4'd8;
    i_mode   = 2'd0;
    i_data   = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_rd",       o_rd,       0);
    check("rst_valid",    o_valid,    0);
    check("rst_data",     o_data,     0);
    check("rst_empty",    o_empty,    1);
    check("rst_level",    o_level,    0);
    check("rst_overflow", o_overflow, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Latency: o_rd in cycle n, buffer non-empty from n+4, read data at n+5.
    push(12'hABC, 2'd0);
    #1 check("rd_issue", o_rd, 1);
    repeat (3) @(negedge clk);
    check("empty_n3", o_empty, 1);
    @(negedge clk);
    check("empty_n4", o_empty, 0);
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    check("pass_valid", o_valid, 1);
    check("pass_data",  o_data,  12'hABC);
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    check("rd_empty_valid", o_valid, 0);

    push(12'hF00, 2'd1); push(12'h0F0, 2'd1); push(12'hFFF, 2'd1);
    drain(3);
    check("grey0", got[0], 12'h444);
    check("grey1", got[1], 12'h888);
    check("grey2", got[2], 12'hFFF);

    push(12'h0F0, 2'd2); push(12'hF00, 2'd2); push(12'h123, 2'd3);
    drain(3);
    check("bin_hi", got[0], 12'hFFF);
    check("bin_lo", got[1], 12'h000);
    check("invert", got[2], 12'hEDC);

    push(12'hF00, 2'd0); push(12'hF00, 2'd1); push(12'hF00, 2'd0); push(12'hF00, 2'd1);
    drain(4);
    check("alt0", got[0], 12'hF00);
    check("alt1", got[1], 12'h444);
    check("alt2", got[2], 12'hF00);
    check("alt3", got[3], 12'h444);

    // Fill past capacity; the buffer must stop at exactly 512 with no overflow.
    for (int i = 0; i < 600; i++) push(12'(i * 7 + 3), 2'(i % 4));
    wait_level(512, 3000);
    repeat (10) @(negedge clk);
    check("full_level",    o_level,    512);
    check("full_rd",       o_rd,       0);
    check("full_pending",  i_empty,    0);
    check("full_overflow", o_overflow, 0);
    out0 = n_out;
    cyc  = 0;
    i_rd = 1'b1;
    while (n_out - out0 < 600 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    i_rd = 1'b0;
    @(negedge clk);
    check("drain600_count", n_out - out0, 600);
    check("drain600_empty", o_empty, 1);

    // Mid-stream reset with five pixels buffered and one pending upstream.
    for (int i = 1; i <= 5; i++) push(12'(12'h100 + i), 2'd0);
    wait_level(5, 200);
    push(12'h7E7, 2'd0);
    #1 check("pre_rst_rd", o_rd, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rd",    o_rd,    0);
    check("mid_rst_empty", o_empty, 1);
    check("mid_rst_level", o_level, 0);
    check("mid_rst_valid", o_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    push(12'h5A5, 2'd0);
    push(12'h3C3, 2'd3);
    drain(2);
    check("restart0", got[0], 12'h5A5);
    check("restart1", got[1], 12'hC3C);
    repeat (4) @(negedge clk);
    check("final_level",    o_level,      0);
    check("final_expected", exp_q.size(), 0);
    check("final_overflow", o_overflow,   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
